// File: rtl/song_sequencer_pkg.sv
// Shared types and field layout for the song sequencer: parameter defaults, FSM states,
// and where the note and duration fields sit inside a song ROM word.
package song_sequencer_pkg;

  localparam int BEAT_BITS_DEF = 7;
  localparam int NOTE_BITS_DEF = 6;

  // ROM word is {note, duration}: duration occupies the low bits
  localparam int DUR_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  function automatic int note_lsb(input int beat_bits);
    return DUR_LSB + beat_bits;
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Beat tick generator: counts TICKS_PER_BEAT run cycles per beat and pulses new_beat on the wrap.
// Pulse is combinational in the wrap cycle; run low freezes the count, clear forces it to 0.
module beat_timer #(
  parameter int TICKS_PER_BEAT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic new_beat
);

  localparam int TW = $clog2(TICKS_PER_BEAT);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BEAT - 1);

  logic [TW-1:0] tick_q, tick_d;

  always_comb begin
    tick_d   = tick_q;
    new_beat = 1'b0;
    if (clear) begin
      tick_d = '0;
    end else if (run) begin
      if (tick_q == TICK_LAST) begin
        tick_d   = '0;
        new_beat = 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tick_q <= '0;
    else      tick_q <= tick_d;
  end

endmodule

// File: rtl/song_sequencer.sv
// Steps through a synchronous song ROM (fetch, load, issue, wait duration beats); play low pauses.
// SONG_SEQUENCER_LOOP_EN: end of song wraps to address 0 instead of parking in DONE.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int BEAT_BITS      = BEAT_BITS_DEF,
  parameter int NOTE_BITS      = NOTE_BITS_DEF,
  parameter int ADDR_BITS      = 7,
  parameter int TICKS_PER_BEAT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           play,
  input  logic                           restart,
  output logic [ADDR_BITS-1:0]           rom_addr,
  input  logic [NOTE_BITS+BEAT_BITS-1:0] rom_data,
  output logic                           new_note,
  output logic [NOTE_BITS-1:0]           note,
  output logic [BEAT_BITS-1:0]           duration,
  output logic                           new_beat,
  output logic                           done
);

  localparam int NOTE_LSB = note_lsb(BEAT_BITS);
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = '1;
  localparam logic [BEAT_BITS-1:0] BEAT_ONE  = BEAT_BITS'(1);

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [NOTE_BITS-1:0] note_q, note_d;
  logic [BEAT_BITS-1:0] dur_q, dur_d;
  logic [BEAT_BITS-1:0] beats_q, beats_d;
  logic [NOTE_BITS-1:0] rom_note;
  logic [BEAT_BITS-1:0] rom_dur;
  logic                 beat;
  logic                 timer_run;
  logic                 timer_clear;
  logic                 end_song;

  assign rom_note = rom_data[NOTE_LSB +: NOTE_BITS];
  assign rom_dur  = rom_data[DUR_LSB +: BEAT_BITS];

  assign timer_run   = (state_q == ST_WAIT) && play && !restart;
  assign timer_clear = restart || (state_q == ST_ISSUE);

  beat_timer #(
    .TICKS_PER_BEAT(TICKS_PER_BEAT)
  ) u_beat_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .run      (timer_run),
    .new_beat (beat)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    note_d   = note_q;
    dur_d    = dur_q;
    beats_d  = beats_q;
    new_note = 1'b0;
    end_song = 1'b0;
    if (restart) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      beats_d = '0;
    end else if (play) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FETCH;
          addr_d  = '0;
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          // zero duration marks the end of the song
          if (rom_dur == '0) begin
            end_song = 1'b1;
          end else begin
            note_d  = rom_note;
            dur_d   = rom_dur;
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          new_note = 1'b1;
          beats_d  = dur_q;
          state_d  = ST_WAIT;
        end
        ST_WAIT: begin
          if (beat) begin
            beats_d = beats_q - 1'b1;
            if (beats_q == BEAT_ONE) begin
              // the top address never wraps: consuming it ends the song
              if (addr_q == ADDR_LAST) begin
                end_song = 1'b1;
              end else begin
                state_d = ST_FETCH;
                addr_d  = addr_q + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end

    if (end_song) begin
`ifdef SONG_SEQUENCER_LOOP_EN
      state_d = ST_FETCH;
      addr_d  = '0;
`else
      state_d = ST_DONE;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      note_q  <= '0;
      dur_q   <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      beats_q <= beats_d;
    end
  end

  assign rom_addr = addr_q;
  assign note     = note_q;
  assign duration = dur_q;
  assign new_beat = beat;
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: event-timeline reference model plus directed literal scenarios.
module tb_song_sequencer;

  localparam int BB   = 7;
  localparam int NB   = 6;
  localparam int AB   = 4;
  localparam int T    = 4;
  localparam int MAXT = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          play = 1'b0;
  logic          restart = 1'b0;
  logic [AB-1:0] rom_addr;
  logic [NB+BB-1:0] rom_data = '0;
  logic          new_note;
  logic [NB-1:0] note;
  logic [BB-1:0] duration;
  logic          new_beat;
  logic          done;

  logic [NB+BB-1:0] rom_mem [0:15];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int start;
  int p;

  // timeline of expected events, indexed by count of play-high cycles since IDLE
  int ev_nn   [MAXT];
  int ev_nb   [MAXT];
  int ev_note [MAXT];
  int ev_dur  [MAXT];
  int t_done = 0;
  int cnt = 0;

  int have_prev = 0;
  int prev_dur = 0;
  int beat_run = 0;

  int nn_cyc[$];
  int nn_note[$];
  int nn_dur[$];
  int nb_cyc[$];
  int done_cyc = -1;

  song_sequencer #(
    .BEAT_BITS(BB), .NOTE_BITS(NB), .ADDR_BITS(AB), .TICKS_PER_BEAT(T)
  ) dut (
    .clk(clk), .rst(rst), .play(play), .restart(restart),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .new_note(new_note), .note(note), .duration(duration),
    .new_beat(new_beat), .done(done)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  excl_a: assert property (@(posedge clk) disable iff (!rst) !(new_note && new_beat))
    else $error("FAIL excl_assert new_note and new_beat together");

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000;
  endfunction

  task automatic set_rom(input int idx, input int n, input int d);
    rom_mem[idx] = {NB'(n), BB'(d)};
  endtask

  // Song schedule: fetch at f, load at f+1, issue at f+2, beats every T after issue,
  // next fetch one cycle after the last beat.
  task automatic build_timeline();
    int f, a, d, iss;
    for (int i = 0; i < MAXT; i++) begin
      ev_nn[i] = 0; ev_nb[i] = 0; ev_note[i] = 0; ev_dur[i] = 0;
    end
    t_done = 2 * MAXT;
    f = 1;
    a = 0;
    while (f + 2 < MAXT) begin
      d = int'(rom_mem[a][BB-1:0]);
      if (d == 0) begin
`ifdef SONG_SEQUENCER_LOOP_EN
        f = f + 2;
        a = 0;
`else
        t_done = f + 2;
        break;
`endif
      end else begin
        iss = f + 2;
        if (iss + T * d >= MAXT) break;
        ev_nn[iss] = 1;
        ev_note[iss] = int'(rom_mem[a][NB+BB-1:BB]);
        ev_dur[iss] = d;
        for (int j = 1; j <= d; j++) ev_nb[iss + T * j] = 1;
        if (a == 15) begin
`ifdef SONG_SEQUENCER_LOOP_EN
          f = iss + T * d + 1;
          a = 0;
`else
          t_done = iss + T * d + 1;
          break;
`endif
        end else begin
          f = iss + T * d + 1;
          a = a + 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin : cmp
    int exp_nn, exp_nb, exp_done;
    if (!rst) begin
      chk("rst_new_note", 32'(new_note), 0);
      chk("rst_new_beat", 32'(new_beat), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_note", 32'(note), 0);
      chk("rst_duration", 32'(duration), 0);
      chk("rst_rom_addr", 32'(rom_addr), 0);
      cnt = 0;
      have_prev = 0;
    end else begin
      exp_done = (cnt >= t_done) ? 1 : 0;
      exp_nn = 0;
      exp_nb = 0;
      if (play && !restart && cnt < t_done && cnt < MAXT) begin
        exp_nn = ev_nn[cnt];
        exp_nb = ev_nb[cnt];
      end
      if (cnt < MAXT || exp_done == 1) begin
        chk("new_note", 32'(new_note), exp_nn);
        chk("new_beat", 32'(new_beat), exp_nb);
        chk("done", 32'(done), exp_done);
        if (exp_nn == 1 && new_note) begin
          chk("note", 32'(note), ev_note[cnt]);
          chk("duration", 32'(duration), ev_dur[cnt]);
        end
      end
      chk("nn_nb_excl", 32'(new_note & new_beat), 0);
      if (new_beat) begin
        nb_cyc.push_back(cyc);
        beat_run++;
      end
      if (new_note) begin
        if (have_prev == 1) chk("beats_between_notes", beat_run, prev_dur);
        have_prev = 1;
        prev_dur = int'(duration);
        beat_run = 0;
        nn_cyc.push_back(cyc);
        nn_note.push_back(int'(note));
        nn_dur.push_back(int'(duration));
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      if (restart) begin
        cnt = 0;
        have_prev = 0;
      end else if (play) begin
        cnt++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    nn_cyc.delete();
    nn_note.delete();
    nn_dur.delete();
    nb_cyc.delete();
    done_cyc = -1;
  endtask

  task automatic start_song();
    rst = 1'b0;
    play = 1'b0;
    restart = 1'b0;
    build_timeline();
    cycles(2);
    rst = 1'b1;
    cycles(1);
    play = 1'b1;
    start = cyc;
    clear_log();
  endtask

  task automatic load_song_a();
    for (int i = 0; i < 16; i++) rom_mem[i] = '0;
    set_rom(0, 27, 2);
    set_rom(1, 28, 1);
    set_rom(2, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = '0;
    build_timeline();
    cycles(3);

    // basic song: note 27 x2 beats, note 28 x1 beat, then end marker
    load_song_a();
    start_song();
    cycles(30);
    chk("a_nn0_cycle", qget(nn_cyc, 0) - start, 3);
    chk("a_nn0_note", qget(nn_note, 0), 27);
    chk("a_nn0_dur", qget(nn_dur, 0), 2);
    chk("a_nb0_cycle", qget(nb_cyc, 0) - start, 7);
    chk("a_nb1_cycle", qget(nb_cyc, 1) - start, 11);
    chk("a_nn1_cycle", qget(nn_cyc, 1) - start, 14);
    chk("a_nn1_note", qget(nn_note, 1), 28);
    chk("a_nb2_cycle", qget(nb_cyc, 2) - start, 18);
`ifdef SONG_SEQUENCER_LOOP_EN
    chk("a_loop_nn2_cycle", qget(nn_cyc, 2) - start, 23);
    chk("a_loop_nn2_note", qget(nn_note, 2), 27);
    chk("a_loop_done", done_cyc, -1);
`else
    chk("a_done_cycle", done_cyc - start, 21);
    chk("a_nn_count", nn_cyc.size(), 2);
`endif

    // pause 10 cycles during the first note's WAIT
    load_song_a();
    start_song();
    cycles(5);
    play = 1'b0;
    cycles(10);
    play = 1'b1;
    cycles(15);
    chk("p_nn0_cycle", qget(nn_cyc, 0) - start, 3);
    chk("p_nb0_cycle", qget(nb_cyc, 0) - start, 17);
    chk("p_nb1_cycle", qget(nb_cyc, 1) - start, 21);
    chk("p_nn1_cycle", qget(nn_cyc, 1) - start, 24);

    // restart during the second note's WAIT
    load_song_a();
    start_song();
    cycles(16);
    restart = 1'b1;
    cycles(1);
    restart = 1'b0;
    cycles(10);
    chk("r_nn2_cycle", qget(nn_cyc, 2) - start, 20);
    chk("r_nn2_note", qget(nn_note, 2), 27);
    chk("r_nb2_cycle", qget(nb_cyc, 2) - start, 24);
    chk("r_nb_count", nb_cyc.size(), 3);

    // reset asserted in the ISSUE cycle
    load_song_a();
    start_song();
    cycles(3);
    rst = 1'b0;
    #1;
    chk("x_async_new_note", 32'(new_note), 0);
    chk("x_async_note", 32'(note), 0);
    chk("x_async_duration", 32'(duration), 0);
    chk("x_async_rom_addr", 32'(rom_addr), 0);
    play = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(6);
    chk("x_no_note_while_idle", nn_cyc.size(), 0);
    play = 1'b1;
    p = cyc;
    cycles(6);
    chk("x_nn_after_play", qget(nn_cyc, 0) - p, 3);
    chk("x_nn_note", qget(nn_note, 0), 27);

    // randomized songs against the timeline model
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 16; i++) begin
        int d;
        d = (s == 2) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 5));
        if (s == 5 && i == 0) d = 0;
        set_rom(i, int'($urandom_range(1, 63)), d);
      end
      start_song();
      for (int c = 0; c < 400; c++) begin
        cycles(1);
        play = ($urandom_range(0, 99) < 85);
        restart = ($urandom_range(0, 199) == 0);
        rst = ($urandom_range(0, 299) != 0);
      end
      restart = 1'b0;
      rst = 1'b1;
      cycles(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
